// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_mp_sweep data memory: access modes, FSM states,
// lane-enable and misalignment helpers.
package dmem_pkg;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Byte lanes touched by an access; illegal mode touches none.
    function automatic logic [3:0] lane_mask(input logic [1:0] mode, input logic [1:0] a);
        logic [3:0] m;
        m = '0;
        case (mode)
            MODE_WORD: m = 4'b1111;
            MODE_BYTE: m = 4'b0001 << a;
            MODE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default:   m = '0;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (mode)
            MODE_WORD: mis = (a != 2'b00);
            MODE_HALF: mis = a[0];
            MODE_ILL:  mis = 1'b1;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane8.sv
// One 8-bit byte lane of the data memory: synchronous write port and NRD
// asynchronous read ports.
module dmem_lane8 #(
    parameter int AW  = 10,
    parameter int NRD = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [7:0]        wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*8-1:0]  rdata
);

    logic [7:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        assign rdata[g*8 +: 8] = r_mem[raddr[g*AW +: AW]];
    end

endmodule

// File: rtl/dmem_mp_sweep.sv
// Byte-addressable data memory with one load/store port, NEXTRA raw-word read
// ports and a one-word-per-cycle clear sweep.
module dmem_mp_sweep
    import dmem_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int NEXTRA = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     str,
    input  logic [1:0]               mode,
    input  logic                     sext,
    input  logic [AWIDTH-1:0]        address,
    input  logic [31:0]              data_in,
    output logic [31:0]              dout,
    input  logic [NEXTRA*AWIDTH-1:0] extra_address,
    output logic [NEXTRA*32-1:0]     extra_dout,
    output logic                     busy,
    output logic                     misalign,
    output logic [7:0]               misalign_cnt
);

    localparam int WAW = AWIDTH - 2;
    localparam int NRD = NEXTRA + 1;

    state_t           r_state;
    logic [WAW-1:0]   r_ptr;
    logic [7:0]       r_misalign_cnt;

    logic             w_busy;
    logic             w_mis_raw;
    logic             w_sweep;
    logic             w_store;
    logic             w_we;
    logic [3:0]       w_mask;
    logic [WAW-1:0]   w_waddr;
    logic [31:0]      w_wdata;
    logic [NRD*WAW-1:0] w_raddr;
    logic [NRD*8-1:0] w_lrd [4];
    logic [31:0]      w_word [NRD];
    logic [31:0]      w_sh;
    logic [31:0]      w_ld;
    logic [2*NEXTRA-1:0] w_unused;

    assign w_busy    = (r_state == CLEAR);
    assign w_mis_raw = is_misaligned(mode, address[1:0]);
    assign w_sweep   = w_busy & ~clr;
    assign w_store   = (r_state == IDLE) & str & ~w_mis_raw & ~clr;
    assign w_we      = w_sweep | w_store;
    assign w_mask    = w_sweep ? 4'b1111 : lane_mask(mode, address[1:0]);
    assign w_waddr   = w_sweep ? r_ptr : address[AWIDTH-1:2];

    // Replicating the store data across lanes puts it under every lane the mask can select.
    always_comb begin
        w_wdata = '0;
        if (!w_sweep) begin
            case (mode)
                MODE_BYTE: w_wdata = {4{data_in[7:0]}};
                MODE_HALF: w_wdata = {2{data_in[15:0]}};
                default:   w_wdata = data_in;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state        <= CLEAR;
            r_ptr          <= '0;
            r_misalign_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (str && w_mis_raw && (r_misalign_cnt != 8'hFF)) begin
                        r_misalign_cnt <= r_misalign_cnt + 8'd1;
                    end
                end
                CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (&r_ptr) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_raddr[0 +: WAW] = address[AWIDTH-1:2];
    for (genvar g = 0; g < NEXTRA; g++) begin : g_xaddr
        assign w_raddr[(g+1)*WAW +: WAW] = extra_address[g*AWIDTH+2 +: WAW];
        assign w_unused[2*g +: 2]        = extra_address[g*AWIDTH +: 2];
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        dmem_lane8 #(
            .AW  (WAW),
            .NRD (NRD)
        ) u_lane (
            .clk   (clk),
            .we    (w_we & w_mask[l]),
            .waddr (w_waddr),
            .wdata (w_wdata[l*8 +: 8]),
            .raddr (w_raddr),
            .rdata (w_lrd[l])
        );
    end

    for (genvar p = 0; p < NRD; p++) begin : g_word
        assign w_word[p] = {w_lrd[3][p*8 +: 8], w_lrd[2][p*8 +: 8],
                            w_lrd[1][p*8 +: 8], w_lrd[0][p*8 +: 8]};
    end

    // Legal half accesses are 16-bit aligned, so one byte-granular shift serves both sizes.
    assign w_sh = w_word[0] >> {address[1:0], 3'b000};

    always_comb begin
        w_ld = '0;
        case (mode)
            MODE_WORD: w_ld = w_word[0];
            MODE_BYTE: w_ld = {{24{sext & w_sh[7]}}, w_sh[7:0]};
            MODE_HALF: w_ld = {{16{sext & w_sh[15]}}, w_sh[15:0]};
            default:   w_ld = '0;
        endcase
    end

    assign dout         = (w_busy || w_mis_raw) ? '0 : w_ld;
    assign busy         = w_busy;
    assign misalign     = w_mis_raw & ~w_busy;
    assign misalign_cnt = r_misalign_cnt;

    for (genvar g = 0; g < NEXTRA; g++) begin : g_xout
        assign extra_dout[g*32 +: 32] = w_busy ? '0 : w_word[g+1];
    end

endmodule

// File: tb/tb_dmem_mp_sweep.sv
// Scoreboard bench for dmem_mp_sweep: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_dmem_mp_sweep;

    localparam int AW = 6;
    localparam int NX = 3;

    localparam int S_DOUT = 0;
    localparam int S_BUSY = 1;
    localparam int S_MIS  = 2;
    localparam int S_CNT  = 3;
    localparam int S_X0   = 4;
    localparam int S_X1   = 5;
    localparam int S_X2   = 6;

    logic              clk = 1'b0;
    logic              clr;
    logic              str;
    logic [1:0]        mode;
    logic              sext;
    logic [AW-1:0]     address;
    logic [31:0]       data_in;
    logic [31:0]       dout;
    logic [NX*AW-1:0]  extra_address;
    logic [NX*32-1:0]  extra_dout;
    logic              busy;
    logic              misalign;
    logic [7:0]        misalign_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    string       q_name [$];
    int          q_sel  [$];
    logic [31:0] q_exp  [$];

    always #5 clk = ~clk;

    dmem_mp_sweep #(
        .AWIDTH (AW),
        .NEXTRA (NX)
    ) u_dut (
        .clk           (clk),
        .clr           (clr),
        .str           (str),
        .mode          (mode),
        .sext          (sext),
        .address       (address),
        .data_in       (data_in),
        .dout          (dout),
        .extra_address (extra_address),
        .extra_dout    (extra_dout),
        .busy          (busy),
        .misalign      (misalign),
        .misalign_cnt  (misalign_cnt)
    );

    function automatic logic [31:0] actual(input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            S_DOUT: v = dout;
            S_BUSY: v = {31'b0, busy};
            S_MIS:  v = {31'b0, misalign};
            S_CNT:  v = {24'b0, misalign_cnt};
            S_X0:   v = extra_dout[31:0];
            S_X1:   v = extra_dout[63:32];
            S_X2:   v = extra_dout[95:64];
            default: v = 'x;
        endcase
        return v;
    endfunction

    task automatic expect_val(input string nm, input int sel, input logic [31:0] e);
        q_name.push_back(nm);
        q_sel.push_back(sel);
        q_exp.push_back(e);
    endtask

    // Monitor: inputs are stable between posedge+1 and the next posedge.
    always @(negedge clk) begin
        while (q_sel.size() > 0) begin
            string       nm;
            int          sel;
            logic [31:0] e;
            logic [31:0] a;
            nm  = q_name.pop_front();
            sel = q_sel.pop_front();
            e   = q_exp.pop_front();
            a   = actual(sel);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_xa(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        extra_address = {a2, a1, a0};
    endtask

    // Called in cycle 0 (right after the clr edge); ends after the first accepted store edge.
    task automatic sweep_check();
        for (int c = 0; c < 16; c++) begin
            str     = 1'b1;
            mode    = 2'b00;
            sext    = 1'b0;
            address = (c % 2 == 1) ? AW'(6'h11) : AW'(6'h10);
            data_in = 32'hFFFF_FFFF;
            set_xa(6'h10, 6'h10, 6'h10);
            expect_val("sweep_busy", S_BUSY, 32'd1);
            expect_val("sweep_misalign_forced", S_MIS, 32'd0);
            expect_val("sweep_dout_forced", S_DOUT, 32'd0);
            expect_val("sweep_x0_forced", S_X0, 32'd0);
            if (c == 0) expect_val("sweep_cnt_cleared", S_CNT, 32'd0);
            tick();
        end
        address = 6'h20;
        data_in = 32'h5A5A_5A5A;
        expect_val("sweep_busy_fall", S_BUSY, 32'd0);
        expect_val("sweep_cnt_not_counted", S_CNT, 32'd0);
        expect_val("sweep_idle_misalign", S_MIS, 32'd0);
        tick();
        str = 1'b0;
    endtask

    task automatic read_all(input logic [31:0] w8);
        for (int w = 0; w < 16; w++) begin
            logic [31:0] e;
            e       = (w == 8) ? w8 : 32'd0;
            str     = 1'b0;
            mode    = 2'b00;
            address = AW'(w * 4);
            set_xa(AW'(w * 4), AW'(w * 4), AW'(w * 4));
            expect_val("read_dout", S_DOUT, e);
            expect_val("read_x0", S_X0, e);
            expect_val("read_x1", S_X1, e);
            expect_val("read_x2", S_X2, e);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queued=%0d expected 0", q_sel.size());
        $fatal(1, "watchdog");
    end

    initial begin
        clr     = 1'b1;
        str     = 1'b0;
        mode    = 2'b00;
        sext    = 1'b0;
        address = '0;
        data_in = '0;
        extra_address = '0;
        tick();
        clr = 1'b0;

        // First sweep, then the array is all zero except the first post-sweep store.
        sweep_check();
        read_all(32'h5A5A_5A5A);

        // Word store, then sized loads with both extension settings.
        mode = 2'b00; address = 6'h10; data_in = 32'h8000_80F1; str = 1'b1; sext = 1'b0;
        expect_val("same_cycle_old_data", S_DOUT, 32'd0);
        tick();
        str = 1'b0;
        mode = 2'b01; address = 6'h11; sext = 1'b1;
        expect_val("byte11_sext", S_DOUT, 32'hFFFF_FF80);
        tick();
        sext = 1'b0;
        expect_val("byte11_zext", S_DOUT, 32'h0000_0080);
        tick();
        mode = 2'b10; address = 6'h12; sext = 1'b1;
        expect_val("half12_sext", S_DOUT, 32'hFFFF_8000);
        tick();
        sext = 1'b0;
        expect_val("half12_zext", S_DOUT, 32'h0000_8000);
        tick();
        mode = 2'b01; address = 6'h10; sext = 1'b1;
        expect_val("byte10_sext", S_DOUT, 32'hFFFF_FFF1);
        tick();
        mode = 2'b00;
        expect_val("word10_ignores_sext", S_DOUT, 32'h8000_80F1);
        tick();

        // Byte store keeps the other lanes; extra ports ignore address[1:0].
        mode = 2'b01; address = 6'h11; data_in = 32'hFFFF_FFAB; str = 1'b1; sext = 1'b1;
        expect_val("byte_store_old_data", S_DOUT, 32'hFFFF_FF80);
        tick();
        str = 1'b0; mode = 2'b00; address = 6'h10;
        set_xa(6'h10, 6'h13, 6'h00);
        expect_val("word10_after_byte", S_DOUT, 32'h8000_ABF1);
        expect_val("x0_after_byte", S_X0, 32'h8000_ABF1);
        expect_val("x1_low_bits_ignored", S_X1, 32'h8000_ABF1);
        expect_val("x2_word0", S_X2, 32'd0);
        tick();

        // Misaligned half store is rejected and counted.
        mode = 2'b10; address = 6'h11; data_in = 32'h0000_1234; str = 1'b1;
        expect_val("half11_misalign", S_MIS, 32'd1);
        expect_val("half11_dout_zero", S_DOUT, 32'd0);
        expect_val("cnt_before_reject", S_CNT, 32'd0);
        tick();
        str = 1'b0; mode = 2'b00; address = 6'h10;
        expect_val("cnt_after_reject", S_CNT, 32'd1);
        expect_val("mem_unchanged", S_DOUT, 32'h8000_ABF1);
        expect_val("aligned_no_misalign", S_MIS, 32'd0);
        tick();
        mode = 2'b11;
        expect_val("illegal_mode_misalign", S_MIS, 32'd1);
        expect_val("illegal_mode_dout", S_DOUT, 32'd0);
        tick();

        // 300 misaligned word stores saturate the counter.
        mode = 2'b00; address = 6'h12; data_in = 32'h0; str = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 253) expect_val("cnt_254", S_CNT, 32'd254);
            tick();
        end
        str = 1'b0;
        expect_val("cnt_saturated", S_CNT, 32'd255);
        expect_val("word12_misalign", S_MIS, 32'd1);
        tick();
        address = 6'h10;
        expect_val("mem_after_rejects", S_DOUT, 32'h8000_ABF1);
        tick();

        // clr clears the counter; re-assertion mid-sweep restarts it.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_val("clr_cnt_zero", S_CNT, 32'd0);
        expect_val("clr_busy", S_BUSY, 32'd1);
        tick();
        for (int i = 1; i < 6; i++) begin
            expect_val("early_sweep_busy", S_BUSY, 32'd1);
            tick();
        end
        clr = 1'b1;
        expect_val("early_sweep_busy", S_BUSY, 32'd1);
        tick();
        clr = 1'b0;
        sweep_check();
        read_all(32'h5A5A_5A5A);

        // Independent extra ports, read in the cycle after each store.
        set_xa(6'h00, 6'h04, 6'h08);
        mode = 2'b00; address = 6'h00; data_in = 32'h1111_1111; str = 1'b1;
        tick();
        mode = 2'b00; address = 6'h04; data_in = 32'h2222_2222;
        expect_val("xp0_after_s0", S_X0, 32'h1111_1111);
        expect_val("xp1_after_s0", S_X1, 32'd0);
        expect_val("xp2_after_s0", S_X2, 32'd0);
        tick();
        address = 6'h08; data_in = 32'h3333_3333;
        expect_val("xp0_after_s1", S_X0, 32'h1111_1111);
        expect_val("xp1_after_s1", S_X1, 32'h2222_2222);
        expect_val("xp2_after_s1", S_X2, 32'd0);
        tick();
        str = 1'b0; mode = 2'b01; address = 6'h03; sext = 1'b0;
        expect_val("xp0_after_s2", S_X0, 32'h1111_1111);
        expect_val("xp1_after_s2", S_X1, 32'h2222_2222);
        expect_val("xp2_after_s2", S_X2, 32'h3333_3333);
        expect_val("byte03_load", S_DOUT, 32'h0000_0011);
        tick();

        for (int i = 0; i < 4 && q_sel.size() > 0; i++) @(negedge clk);
        #1;
        if (q_sel.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d checks left in queue, expected 0", q_sel.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
